// File: rtl/zc_stream_packetizer_pkg.sv
// Shared definitions for the zero-crossing stream packetizer.
// - FIFO entries are {tlast, data}: tlast lives at bit index WIDTH, data below.
// - Read-side framer state encoding.
// - Saturation value of the drop counter.
package zc_stream_packetizer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,  // no beat of the current packet sent yet
    ST_IN_PKT = 1'b1   // at least one beat of the current packet sent
  } rd_state_t;

  localparam logic [31:0] DROP_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/zc_stream_packetizer_if.sv
// AXI-Stream style bundle used for the packetizer's input and output streams.
// Ports: tdata (WIDTH), tlast, tvalid, tready.
// master drives tdata/tlast/tvalid, slave drives tready.
interface zc_stream_packetizer_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/zc_stream_packetizer_fifo.sv
// First-word-fall-through FIFO, 2^SIZE entries of WIDTH bits.
// Ports: clk, rst (sync, active-high), clear (flush),
//        i_tdata/i_tvalid/i_tready (write side, i_tready = not full),
//        o_tdata/o_tvalid/o_tready (read side, o_tvalid = not empty).
// Only the pointers are reset; storage contents are don't-care while empty.
module zc_stream_packetizer_fifo #(
  parameter int WIDTH = 33,
  parameter int SIZE  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);
  localparam int DEPTH = 1 << SIZE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SIZE:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, empty, wr_en, rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    full     = (wr_ptr_q[SIZE] != rd_ptr_q[SIZE]) &&
               (wr_ptr_q[SIZE-1:0] == rd_ptr_q[SIZE-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    wr_en    = i_tvalid && !full && !clear;
    rd_en    = o_tready && !empty && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (SIZE+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (SIZE+1)'(1);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[SIZE-1:0]] <= i_tdata;
  end

  assign i_tready = !full;
  assign o_tvalid = !empty;
  assign o_tdata  = mem[rd_ptr_q[SIZE-1:0]];
endmodule

// File: rtl/zc_stream_packetizer.sv
// Packetizer for the combined I/Q zero-crossing moving-average stream.
// Absorbs a no-backpressure input stream, keeps 1 of every decim samples,
// buffers in a FWFT FIFO and emits fixed-length packets with tlast framing.
// Ports: ce_clk, ce_rst (sync, active-high), clear (flush pulse),
//        pkt_len (samples/packet, 0 => 1), decim (0 => 1),
//        s_in  : input stream (tready tied high),
//        m_out : output stream to the shell,
//        drop_count (saturating overflow drops), pkt_count (wrapping).
module zc_stream_packetizer
  import zc_stream_packetizer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FIFO_SIZE = 5,
  parameter int LEN_WIDTH = 12
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [15:0]          decim,
  zc_stream_packetizer_if.slave  s_in,
  zc_stream_packetizer_if.master m_out,
  output logic [31:0]          drop_count,
  output logic [31:0]          pkt_count
);
  logic [15:0]          dcnt_q, dcnt_d, decim_q, decim_d;
  logic [15:0]          eff_decim, cur_decim;
  logic [LEN_WIDTH-1:0] eff_len, cur_len, len_q, len_d, bc_q, bc_d;
  logic [31:0]          drop_count_q, drop_count_d, pkt_count_q, pkt_count_d;
  rd_state_t            state_q, state_d;
  logic                 keep, fifo_wr, fifo_in_ready, fifo_out_valid;
  logic                 head_last, beat;
  logic [WIDTH:0]       fifo_out_data;

  zc_stream_packetizer_fifo #(
    .WIDTH (WIDTH + 1),
    .SIZE  (FIFO_SIZE)
  ) u_fifo (
    .clk      (ce_clk),
    .rst      (ce_rst),
    .clear    (clear),
    .i_tdata  ({s_in.tlast, s_in.tdata}),
    .i_tvalid (fifo_wr),
    .i_tready (fifo_in_ready),
    .o_tdata  (fifo_out_data),
    .o_tvalid (fifo_out_valid),
    .o_tready (m_out.tready)
  );

  always_comb begin
    eff_decim = (decim == 16'd0) ? 16'd1 : decim;
    eff_len   = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;

    // Decimation period is sampled only at dcnt==0, so a decim change
    // lands on the next wrap rather than mid-period.
    cur_decim = (dcnt_q == 16'd0) ? eff_decim : decim_q;
    keep      = s_in.tvalid && (dcnt_q == 16'd0);
    dcnt_d    = dcnt_q;
    decim_d   = decim_q;
    if (s_in.tvalid) begin
      decim_d = cur_decim;
      dcnt_d  = (dcnt_q == cur_decim - 16'd1) ? 16'd0 : dcnt_q + 16'd1;
    end

    // Full flag reflects occupancy at the start of the cycle, so a same-cycle
    // read does not rescue a sample arriving at a full FIFO.
    fifo_wr      = keep && !clear;
    drop_count_d = drop_count_q;
    if (fifo_wr && !fifo_in_ready && (drop_count_q != DROP_SAT))
      drop_count_d = drop_count_q + 32'd1;

    // While idle the live length applies; it is frozen once a beat goes out.
    cur_len   = (state_q == ST_IDLE) ? eff_len : len_q;
    head_last = fifo_out_valid &&
                ((bc_q == cur_len - LEN_WIDTH'(1)) || fifo_out_data[WIDTH]);
    beat      = fifo_out_valid && m_out.tready;

    state_d     = state_q;
    bc_d        = bc_q;
    len_d       = (state_q == ST_IDLE) ? eff_len : len_q;
    pkt_count_d = pkt_count_q;
    if (beat) begin
      if (head_last) begin
        bc_d        = '0;
        state_d     = ST_IDLE;
        pkt_count_d = pkt_count_q + 32'd1;
      end else begin
        bc_d    = bc_q + LEN_WIDTH'(1);
        state_d = ST_IN_PKT;
      end
    end

    if (clear) begin
      dcnt_d       = 16'd0;
      decim_d      = 16'd1;
      bc_d         = '0;
      state_d      = ST_IDLE;
      len_d        = eff_len;
      drop_count_d = '0;
      pkt_count_d  = '0;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      dcnt_q       <= 16'd0;
      decim_q      <= 16'd1;
      bc_q         <= '0;
      len_q        <= LEN_WIDTH'(1);
      state_q      <= ST_IDLE;
      drop_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      dcnt_q       <= dcnt_d;
      decim_q      <= decim_d;
      bc_q         <= bc_d;
      len_q        <= len_d;
      state_q      <= state_d;
      drop_count_q <= drop_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign s_in.tready  = 1'b1;
  assign m_out.tvalid = fifo_out_valid;
  assign m_out.tdata  = fifo_out_valid ? fifo_out_data[WIDTH-1:0] : '0;
  assign m_out.tlast  = head_last;
  assign drop_count   = drop_count_q;
  assign pkt_count    = pkt_count_q;
endmodule
